// File: rtl/irq_arbiter_pkg.sv
// Shared definitions for the interrupt arbiter: default source count,
// index-width derivation and the arbitration FSM state encoding.
package irq_arbiter_pkg;

  localparam int N_SRC_DEF = 16;

  // Width needed to index n sources; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int ID_W_DEF = id_width(N_SRC_DEF);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: returns the lowest set index of req_i (bit 0 wins)
// together with a flag telling whether any bit was set at all.
module irq_prio_enc
  import irq_arbiter_pkg::*;
#(
  parameter int N = N_SRC_DEF,
  parameter int W = id_width(N)
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);

  // Scan from the top down so the last hit recorded is the smallest index.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = W'(i);
        valid_o = 1'b1;
      end else begin
        idx_o   = idx_o;
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Edge-triggered, fixed-priority, non-preemptive interrupt arbiter.
// Rising edges on irq_src_i latch a pending bit; the lowest enabled pending
// source is handed to the core and held until the core signals return.
module irq_arbiter
  import irq_arbiter_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF,
  parameter int ID_W  = id_width(N_SRC)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_SRC-1:0] irq_src_i,
  input  logic [N_SRC-1:0] irq_en_i,
  input  logic             irq_ret_i,
  output logic             irq_req_o,
  output logic [ID_W-1:0]  irq_id_o,
  output logic [N_SRC-1:0] irq_ack_o
);

  state_e           state_q, state_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] src_q, src_d;
  logic             armed_q, armed_d;
  logic             req_q, req_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [N_SRC-1:0] ack_q, ack_d;

  logic [N_SRC-1:0] edge_s;
  logic [N_SRC-1:0] cand_s;
  logic [N_SRC-1:0] cur_onehot_s;
  logic [N_SRC-1:0] clr_s;
  logic [ID_W-1:0]  sel_idx_s;
  logic             sel_valid_s;

  // armed_q is low on the first cycle after reset so a line already high
  // at that point only primes src_q instead of counting as an edge.
  assign edge_s       = irq_src_i & ~src_q & {N_SRC{armed_q}};
  assign cand_s       = pending_q & irq_en_i;
  assign cur_onehot_s = N_SRC'(1'b1) << id_q;

  irq_prio_enc #(
    .N (N_SRC),
    .W (ID_W)
  ) u_prio_enc (
    .req_i   (cand_s),
    .idx_o   (sel_idx_s),
    .valid_o (sel_valid_s)
  );

  // Next-state logic: grant in IDLE, hold in ACTIVE until return; edge set wins over clear.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ack_d   = '0;
    clr_s   = '0;
    src_d   = irq_src_i;
    armed_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (sel_valid_s) begin
          state_d = ACTIVE;
          id_d    = sel_idx_s;
        end else begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (irq_ret_i) begin
          state_d = IDLE;
          clr_s   = cur_onehot_s;
          ack_d   = cur_onehot_s;
        end else begin
          state_d = ACTIVE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    pending_d = (pending_q & ~clr_s) | edge_s;
    req_d     = (state_d == ACTIVE);
  end

  // State registers with synchronous active-low reset; edges seen during reset are dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      pending_q <= '0;
      src_q     <= '0;
      armed_q   <= 1'b0;
      req_q     <= 1'b0;
      id_q      <= '0;
      ack_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      src_q     <= src_d;
      armed_q   <= armed_d;
      req_q     <= req_d;
      id_q      <= id_d;
      ack_q     <= ack_d;
    end
  end

  assign irq_req_o = req_q;
  assign irq_id_o  = id_q;
  assign irq_ack_o = ack_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: directed scenarios followed by a
// randomized run, every cycle compared against a behavioural model.
module tb_irq_arbiter;

  localparam int N = 16;
  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] src;
  logic [N-1:0] en;
  logic         ret;
  logic         dut_req;
  logic [W-1:0] dut_id;
  logic [N-1:0] dut_ack;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  bit          m_pend  [N];
  bit          m_prev  [N];
  bit          m_armed;
  bit          m_active;
  int          m_id;
  logic [N-1:0] m_ack;

  irq_arbiter #(.N_SRC(N), .ID_W(W)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .irq_src_i (src),
    .irq_en_i  (en),
    .irq_ret_i (ret),
    .irq_req_o (dut_req),
    .irq_id_o  (dut_id),
    .irq_ack_o (dut_ack)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one rising clock edge, from the sampled inputs.
  task automatic model_edge();
    int sel;
    m_ack = '0;
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        m_pend[k] = 1'b0;
        m_prev[k] = 1'b0;
      end
      m_armed  = 1'b0;
      m_active = 1'b0;
      m_id     = 0;
    end else begin
      if (m_active) begin
        if (ret) begin
          m_ack[m_id]  = 1'b1;
          m_pend[m_id] = 1'b0;
          m_active     = 1'b0;
        end
      end else begin
        sel = -1;
        for (int k = N - 1; k >= 0; k--)
          if (m_pend[k] && en[k]) sel = k;
        if (sel >= 0) begin
          m_active = 1'b1;
          m_id     = sel;
        end
      end
      for (int k = 0; k < N; k++) begin
        if (m_armed && src[k] && !m_prev[k]) m_pend[k] = 1'b1;
        m_prev[k] = src[k];
      end
      m_armed = 1'b1;
    end
  endtask

  // One clock: advance model at the edge, compare outputs 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("req", {31'd0, dut_req}, {31'd0, m_active});
    chk("id",  {28'd0, dut_id},  m_id);
    chk("ack", {16'd0, dut_ack}, {16'd0, m_ack});
  endtask

  initial begin
    logic [31:0] r;
    m_armed  = 1'b0;
    m_active = 1'b0;
    m_id     = 0;
    m_ack    = '0;
    for (int k = 0; k < N; k++) begin
      m_pend[k] = 1'b0;
      m_prev[k] = 1'b0;
    end
    rst_n = 1'b0;
    src   = 16'h0000;
    en    = 16'hFFFF;
    ret   = 1'b0;
    #1;
    step(); step();
    chk("reset_req", {31'd0, dut_req}, 32'd0);
    chk("reset_ack", {16'd0, dut_ack}, 32'd0);
    rst_n = 1'b1;
    step();

    // Single source 5
    src = 16'h0020; step();
    chk("s5_req_early", {31'd0, dut_req}, 32'd0);
    step();
    chk("s5_req", {31'd0, dut_req}, 32'd1);
    chk("s5_id", {28'd0, dut_id}, 32'd5);
    ret = 1'b1; step();
    chk("s5_ack", {16'd0, dut_ack}, 32'h0020);
    chk("s5_req_drop", {31'd0, dut_req}, 32'd0);
    ret = 1'b0; step();
    chk("s5_ack_once", {16'd0, dut_ack}, 32'h0000);

    // Simultaneous 3 and 9
    src = 16'h0000; step();
    src = 16'h0208; step(); step();
    chk("s39_id_first", {28'd0, dut_id}, 32'd3);
    ret = 1'b1; step();
    chk("s39_ack3", {16'd0, dut_ack}, 32'h0008);
    chk("s39_dwell", {31'd0, dut_req}, 32'd0);
    ret = 1'b0; step();
    chk("s39_id_second", {28'd0, dut_id}, 32'd9);
    chk("s39_req_second", {31'd0, dut_req}, 32'd1);
    ret = 1'b1; step();
    chk("s39_ack9", {16'd0, dut_ack}, 32'h0200);
    ret = 1'b0; step();

    // Masked source 2
    src = 16'h0000; en = 16'hFFFB; step();
    src = 16'h0004; step(); step(); step();
    chk("mask_no_req", {31'd0, dut_req}, 32'd0);
    en = 16'hFFFF; step();
    chk("mask_req", {31'd0, dut_req}, 32'd1);
    chk("mask_id", {28'd0, dut_id}, 32'd2);
    ret = 1'b1; step();
    ret = 1'b0; step();

    // Preemption attempt on id 7
    src = 16'h0000; step();
    src = 16'h0080; step(); step();
    chk("pre_id7", {28'd0, dut_id}, 32'd7);
    src = 16'h0081; step(); step();
    chk("pre_hold7", {28'd0, dut_id}, 32'd7);
    ret = 1'b1; step();
    chk("pre_ack7", {16'd0, dut_ack}, 32'h0080);
    ret = 1'b0; step();
    chk("pre_id0", {28'd0, dut_id}, 32'd0);
    chk("pre_req0", {31'd0, dut_req}, 32'd1);
    ret = 1'b1; step();
    ret = 1'b0; step();

    // Set/clear collision on id 4
    src = 16'h0000; step();
    src = 16'h0010; step(); step();
    src = 16'h0000; step();
    src = 16'h0010; ret = 1'b1; step();
    chk("col_ack", {16'd0, dut_ack}, 32'h0010);
    chk("col_drop", {31'd0, dut_req}, 32'd0);
    ret = 1'b0; step();
    chk("col_rereq", {31'd0, dut_req}, 32'd1);
    chk("col_id", {28'd0, dut_id}, 32'd4);
    ret = 1'b1; step();
    ret = 1'b0; step();

    // Reset mid-service, line held high through reset
    src = 16'h0000; step();
    src = 16'h0040; step(); step();
    chk("rst_active", {31'd0, dut_req}, 32'd1);
    rst_n = 1'b0; step();
    chk("rst_req", {31'd0, dut_req}, 32'd0);
    chk("rst_id", {28'd0, dut_id}, 32'd0);
    chk("rst_ack", {16'd0, dut_ack}, 32'h0000);
    step();
    rst_n = 1'b1; step(); step(); step();
    chk("rst_no_retrig", {31'd0, dut_req}, 32'd0);

    // Randomized run against the model
    for (int c = 0; c < 600; c++) begin
      r   = $urandom & $urandom & $urandom;
      src = src ^ r[15:0];
      r   = $urandom | $urandom;
      en  = r[15:0];
      ret = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_arbiter.md
IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 The module SHALL have parameter N_SRC, default 16, meaning the number of peripheral interrupt sources (2..32).
REQ-002 The module SHALL have parameter ID_W, default $clog2(N_SRC), meaning the width of the source index.
REQ-003 The module SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 The module SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-005 The module SHALL have port irq_src_i  input  N_SRC  per-source interrupt lines, rising-edge significant.
REQ-006 The module SHALL have port irq_en_i  input  N_SRC  per-source enable mask for arbitration.
REQ-007 The module SHALL have port irq_ret_i  input  1  core return-from-interrupt pulse (mret).
REQ-008 The module SHALL have port irq_req_o  output  1  interrupt request to core, level.
REQ-009 The module SHALL have port irq_id_o  output  ID_W  index of the source being serviced.
REQ-010 The module SHALL have port irq_ack_o  output  N_SRC  one-hot, one-cycle service-complete pulse to the serviced source.

Function
REQ-011 The module SHALL register irq_src_i each cycle and detect a rising edge as src & ~src_q.
REQ-012 The module SHALL set pending[k] on a rising edge of source k regardless of irq_en_i[k].
REQ-013 An edge on an already-pending source SHALL be absorbed, with no counting and no error.
REQ-014 The module SHALL implement an FSM with states IDLE and ACTIVE.
REQ-015 In IDLE, if (pending & irq_en_i) != 0, the module SHALL select the lowest set index (fixed priority, bit 0 highest), latch it into irq_id_o, and enter ACTIVE on the next edge.
REQ-016 irq_req_o SHALL be registered and equal 1 exactly while in ACTIVE, so it asserts one cycle after the pending bit is first visible.
REQ-017 In ACTIVE, irq_id_o SHALL be frozen, ignoring new higher-priority edges and irq_en_i changes (no preemption).
REQ-018 In ACTIVE with irq_ret_i=1, the module SHALL clear pending[irq_id_o], pulse irq_ack_o[irq_id_o] for one cycle, and return to IDLE on the next edge.
REQ-019 If a rising edge on source irq_id_o coincides with irq_ret_i, pending SHALL remain set (set wins over clear), and the ack pulse SHALL still be issued.
REQ-020 irq_ret_i in IDLE SHALL be ignored, with no state change and no ack.
REQ-021 After leaving ACTIVE, irq_req_o SHALL be low for at least one full cycle before the next request (IDLE dwell of at least one cycle).
REQ-022 irq_id_o SHALL hold its last value in IDLE.
REQ-023 irq_ack_o SHALL be zero in all cycles other than those defined by REQ-018.

Reset
REQ-024 While rst_ni=0 at a clock edge, the module SHALL enter IDLE and clear pending, src_q, irq_req_o, irq_id_o and irq_ack_o to 0.
REQ-025 Reset asserted in ACTIVE SHALL abort the service with no ack pulse issued.
REQ-026 Edges present during reset SHALL be lost.
REQ-027 src_q SHALL load the live irq_src_i value on the first cycle after reset, so a line already high is not treated as an edge.

Structure
REQ-028 A package irq_arbiter_pkg SHALL hold the N_SRC default, the ID_W derivation, and the FSM state enum (IDLE, ACTIVE).
REQ-029 A combinational sub-module irq_prio_enc SHALL take an N_SRC request vector and return the lowest set index plus a valid flag.
REQ-030 The module SHALL contain no other sub-modules, no latches, and no multiple clocks.

Verification
REQ-031 Scenario: single source, edge on src[5], en=all ones -> irq_req_o=1 two cycles after the edge, irq_id_o=5; ret pulse -> irq_ack_o=0x0020 for one cycle, then irq_req_o=0.
REQ-032 Scenario: edges on src[3] and src[9] in the same cycle -> id=3 serviced first; after ret, req low for at least one cycle, then id=9; two acks total (0x0008, then 0x0200).
REQ-033 Scenario: masked source, edge on src[2] with en[2]=0 -> no request; raise en[2] later -> irq_req_o=1 with id=2 next cycle.
REQ-034 Scenario: preemption attempt, ACTIVE on id=7 when src[0] rises -> id stays 7 until ret; then id=0 is serviced.
REQ-035 Scenario: set/clear collision, src[4] re-rises in the ret cycle of id=4 -> ack pulse issued, req drops for one cycle, then re-asserts with id=4.
REQ-036 Scenario: reset mid-service, rst_ni=0 while ACTIVE -> next cycle all outputs 0 and no ack; a line held high through reset does not re-trigger.
